// File: rtl/arm_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : arm_decode_if
// Brief    : Fetch-side and execute-side handshake bundle for arm_decode_stage.
// Revision : 1.0
// ============================================================================
interface arm_decode_if #(
  parameter int REG_AW = 4
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [31:0]         in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          out_class;
  logic [3:0]          out_cond;
  logic [3:0]          out_alu_sel;
  logic                out_set_flags;
  logic [4*REG_AW-1:0] out_regs;
  logic [31:0]         out_imm;
  logic                out_imm_valid;
  logic [7:0]          out_shift;
  logic                out_link_acc;
  logic [31:0]         out_pc;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_class, out_cond, out_alu_sel, out_set_flags,
           out_regs, out_imm, out_imm_valid, out_shift, out_link_acc, out_pc
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_class, out_cond, out_alu_sel, out_set_flags,
           out_regs, out_imm, out_imm_valid, out_shift, out_link_acc, out_pc
  );
endinterface
`default_nettype wire

// File: rtl/arm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : arm_decode_stage
// Brief    : Registered ARMv4-subset decode stage feeding a small output FIFO.
// Revision : 1.0
// ============================================================================
module arm_decode_stage #(
  parameter int REG_AW = 4,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  arm_decode_if.slave bus
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int RW = 4 * REG_AW;

  localparam logic [CW-1:0] c_FULL    = CW'(QDEPTH);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  localparam logic [2:0] c_CLS_DP    = 3'd0;
  localparam logic [2:0] c_CLS_MUL   = 3'd1;
  localparam logic [2:0] c_CLS_LDST  = 3'd2;
  localparam logic [2:0] c_CLS_BR    = 3'd3;
  localparam logic [2:0] c_CLS_SWI   = 3'd4;
  localparam logic [2:0] c_CLS_UNDEF = 3'd7;

  typedef struct packed {
    logic [2:0]    cls;
    logic [3:0]    cond;
    logic [3:0]    alu_sel;
    logic          set_flags;
    logic [RW-1:0] regs;
    logic [31:0]   imm;
    logic          imm_valid;
    logic [7:0]    shift;
    logic          link_acc;
    logic [31:0]   pc;
  } entry_t;

  logic [31:0] w_inst;
  logic [31:0] w_imm8;
  logic [4:0]  w_rot_amt;
  logic [31:0] w_rot_imm;
  logic [3:0]  w_rn;
  logic [3:0]  w_rd;
  logic [3:0]  w_rm;
  logic [3:0]  w_rs;
  entry_t      w_dec;

  assign w_inst    = bus.in_inst;
  assign w_imm8    = {24'h0, w_inst[7:0]};
  assign w_rot_amt = {w_inst[11:8], 1'b0};
  // A shift by 32 yields zero, so rotate-by-0 falls out of the same expression.
  assign w_rot_imm = (w_imm8 >> w_rot_amt) | (w_imm8 << (6'd32 - {1'b0, w_rot_amt}));

  always_comb begin
    w_dec      = '0;
    w_dec.cond = w_inst[31:28];
    w_dec.pc   = bus.in_pc;
    w_rn       = 4'h0;
    w_rd       = 4'h0;
    w_rm       = 4'h0;
    w_rs       = 4'h0;
    if (w_inst[31:28] == 4'hF) begin
      w_dec.cls = c_CLS_UNDEF;
    end else if (w_inst[27:24] == 4'hF) begin
      w_dec.cls       = c_CLS_SWI;
      w_dec.imm       = {8'h0, w_inst[23:0]};
      w_dec.imm_valid = 1'b1;
    end else if (w_inst[27:25] == 3'b101) begin
      w_dec.cls      = c_CLS_BR;
      w_dec.imm      = {{6{w_inst[23]}}, w_inst[23:0], 2'b00};
      w_dec.link_acc = w_inst[24];
    end else if ((w_inst[27:22] == 6'h00) && (w_inst[7:4] == 4'b1001)) begin
      // Multiply swaps the usual rd/rn positions.
      w_dec.cls       = c_CLS_MUL;
      w_dec.alu_sel   = {3'b000, w_inst[21]};
      w_dec.set_flags = w_inst[20];
      w_dec.link_acc  = w_inst[21];
      w_rd            = w_inst[19:16];
      w_rn            = w_inst[15:12];
      w_rs            = w_inst[11:8];
      w_rm            = w_inst[3:0];
    end else if (w_inst[27:26] == 2'b01) begin
      w_dec.cls     = c_CLS_LDST;
      w_dec.alu_sel = w_inst[23] ? 4'b0100 : 4'b0010;
      w_rn          = w_inst[19:16];
      w_rd          = w_inst[15:12];
      if (!w_inst[25]) begin
        w_dec.imm       = {20'h0, w_inst[11:0]};
        w_dec.imm_valid = 1'b1;
      end else begin
        w_rm        = w_inst[3:0];
        w_dec.shift = {1'b0, w_inst[6:5], w_inst[11:7]};
      end
    end else if ((w_inst[27:26] == 2'b00) && (w_inst[24:23] == 2'b10) && !w_inst[20]) begin
      // Compare/test opcodes without S are not plain data processing here.
      w_dec.cls = c_CLS_UNDEF;
    end else if (w_inst[27:26] == 2'b00) begin
      w_dec.cls       = c_CLS_DP;
      w_dec.alu_sel   = w_inst[24:21];
      w_dec.set_flags = w_inst[20];
      w_rn            = w_inst[19:16];
      w_rd            = w_inst[15:12];
      if (w_inst[25]) begin
        w_dec.imm       = w_rot_imm;
        w_dec.imm_valid = 1'b1;
      end else if (!w_inst[4]) begin
        w_rm        = w_inst[3:0];
        w_dec.shift = {1'b0, w_inst[6:5], w_inst[11:7]};
      end else begin
        w_rm        = w_inst[3:0];
        w_rs        = w_inst[11:8];
        w_dec.shift = {1'b1, w_inst[6:5], 5'h00};
      end
    end else begin
      w_dec.cls = c_CLS_UNDEF;
    end
    w_dec.regs = {REG_AW'(w_rn), REG_AW'(w_rd), REG_AW'(w_rm), REG_AW'(w_rs)};
  end

  entry_t        r_mem [QDEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  entry_t        w_head;

  assign w_full        = (r_count == c_FULL);
  assign bus.in_ready  = rst_n & ~w_full;
  assign bus.out_valid = (r_count != '0);
  assign w_push        = bus.in_valid & bus.in_ready & ~bus.flush;
  assign w_pop         = bus.out_valid & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  assign w_head            = r_mem[r_rd_ptr];
  assign bus.out_class     = w_head.cls;
  assign bus.out_cond      = w_head.cond;
  assign bus.out_alu_sel   = w_head.alu_sel;
  assign bus.out_set_flags = w_head.set_flags;
  assign bus.out_regs      = w_head.regs;
  assign bus.out_imm       = w_head.imm;
  assign bus.out_imm_valid = w_head.imm_valid;
  assign bus.out_shift     = w_head.shift;
  assign bus.out_link_acc  = w_head.link_acc;
  assign bus.out_pc        = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_arm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_decode_stage
// Brief    : Directed self-checking bench for arm_decode_stage.
// Revision : 1.0
// ============================================================================
module tb_arm_decode_stage;

  localparam int REG_AW = 4;
  localparam int QDEPTH = 2;
  localparam int NVEC   = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  arm_decode_if #(.REG_AW(REG_AW)) bus ();

  arm_decode_stage #(.REG_AW(REG_AW), .QDEPTH(QDEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [101:0] obs;
  assign obs = {bus.out_class, bus.out_cond, bus.out_alu_sel, bus.out_set_flags,
                bus.out_regs, bus.out_imm, bus.out_imm_valid, bus.out_shift,
                bus.out_link_acc, bus.out_pc};

  logic [31:0] v_inst [NVEC];
  logic [69:0] v_exp  [NVEC];

  // {class, cond, alu_sel, set_flags, regs, imm, imm_valid, shift, link_acc}
  function automatic logic [69:0] ef(input logic [2:0] c, input logic [3:0] cd,
                                     input logic [3:0] a, input logic s,
                                     input logic [15:0] r, input logic [31:0] im,
                                     input logic iv, input logic [7:0] sh,
                                     input logic l);
    return {c, cd, a, s, r, im, iv, sh, l};
  endfunction

  task automatic idle();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (obs !== 102'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0",
                         bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_decode_classes();
    v_inst[0]  = 32'hE3A004FF; v_exp[0]  = ef(3'd0, 4'hE, 4'hD, 1'b0, 16'h0000, 32'hFF000000, 1'b1, 8'h00, 1'b0);
    v_inst[1]  = 32'hE0921203; v_exp[1]  = ef(3'd0, 4'hE, 4'h4, 1'b1, 16'h2130, 32'h0,        1'b0, 8'h04, 1'b0);
    v_inst[2]  = 32'hE0821433; v_exp[2]  = ef(3'd0, 4'hE, 4'h4, 1'b0, 16'h2134, 32'h0,        1'b0, 8'hA0, 1'b0);
    v_inst[3]  = 32'hE1100000; v_exp[3]  = ef(3'd0, 4'hE, 4'h8, 1'b1, 16'h0000, 32'h0,        1'b0, 8'h00, 1'b0);
    v_inst[4]  = 32'hE5910010; v_exp[4]  = ef(3'd2, 4'hE, 4'h4, 1'b0, 16'h1000, 32'h10,       1'b1, 8'h00, 1'b0);
    v_inst[5]  = 32'hE7032104; v_exp[5]  = ef(3'd2, 4'hE, 4'h2, 1'b0, 16'h3240, 32'h0,        1'b0, 8'h02, 1'b0);
    v_inst[6]  = 32'hEAFFFFFE; v_exp[6]  = ef(3'd3, 4'hE, 4'h0, 1'b0, 16'h0000, 32'hFFFFFFF8, 1'b0, 8'h00, 1'b0);
    v_inst[7]  = 32'hEB000010; v_exp[7]  = ef(3'd3, 4'hE, 4'h0, 1'b0, 16'h0000, 32'h40,       1'b0, 8'h00, 1'b1);
    v_inst[8]  = 32'hEF123456; v_exp[8]  = ef(3'd4, 4'hE, 4'h0, 1'b0, 16'h0000, 32'h00123456, 1'b1, 8'h00, 1'b0);
    v_inst[9]  = 32'hE0020391; v_exp[9]  = ef(3'd1, 4'hE, 4'h0, 1'b0, 16'h0213, 32'h0,        1'b0, 8'h00, 1'b0);
    v_inst[10] = 32'hE0324391; v_exp[10] = ef(3'd1, 4'hE, 4'h1, 1'b1, 16'h4213, 32'h0,        1'b0, 8'h00, 1'b1);
    v_inst[11] = 32'hF3A010FF; v_exp[11] = ef(3'd7, 4'hF, 4'h0, 1'b0, 16'h0000, 32'h0,        1'b0, 8'h00, 1'b0);
    v_inst[12] = 32'hE1000000; v_exp[12] = ef(3'd7, 4'hE, 4'h0, 1'b0, 16'h0000, 32'h0,        1'b0, 8'h00, 1'b0);
    v_inst[13] = 32'hEE000000; v_exp[13] = ef(3'd7, 4'hE, 4'h0, 1'b0, 16'h0000, 32'h0,        1'b0, 8'h00, 1'b0);
    for (int i = 0; i < NVEC; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(i * 4);
      push_one(v_inst[i], pc);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== {v_exp[i], pc}) begin
        errors++;
        $display("FAIL decode_%08h: got valid=%b fields=%h expected valid=1 fields=%h",
                 v_inst[i], bus.out_valid, obs, {v_exp[i], pc});
      end
      pop_one();
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL decode_drained: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'hE3A004FF;
    bus.in_pc    = 32'h200;
    step();
    bus.in_inst = 32'hEAFFFFFE;
    bus.in_pc   = 32'h204;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_pc !== 32'h200) begin
      errors++; $display("FAIL b2b_first: got in_ready=%b pc=%h expected 1/00000200",
                         bus.in_ready, bus.out_pc);
    end
    step();
    bus.in_inst = 32'hE0020391;
    bus.in_pc   = 32'h208;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_full: got in_ready=%b out_valid=%b expected 0/1",
                         bus.in_ready, bus.out_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_pc !== 32'h200 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_stall: got pc=%h in_ready=%b expected 00000200/0",
                         bus.out_pc, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (bus.out_pc !== 32'h204 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_pop_only: got pc=%h in_ready=%b expected 00000204/1",
                         bus.out_pc, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h208 || bus.out_class !== 3'd1) begin
      errors++; $display("FAIL b2b_third: got valid=%b pc=%h class=%0d expected 1/00000208/1",
                         bus.out_valid, bus.out_pc, bus.out_class);
    end
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drained: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    push_one(32'hE3A004FF, 32'h300);
    push_one(32'hE0020391, 32'h304);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_pre: got valid=%b in_ready=%b expected 1/0",
                         bus.out_valid, bus.in_ready);
    end
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'hEF000001;
    bus.in_pc     = 32'h308;
    bus.out_ready = 1'b1;
    step();
    idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty: got valid=%b in_ready=%b expected 0/1",
                         bus.out_valid, bus.in_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got out_valid=%b expected 0", bus.out_valid);
    end
    push_one(32'hEB000010, 32'h30C);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h30C || bus.out_link_acc !== 1'b1) begin
      errors++; $display("FAIL flush_recover: got valid=%b pc=%h link=%b expected 1/0000030c/1",
                         bus.out_valid, bus.out_pc, bus.out_link_acc);
    end
    pop_one();
  endtask

  task automatic test_reset_mid_drain();
    push_one(32'hE3A004FF, 32'h400);
    push_one(32'hE0921203, 32'h404);
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h404) begin
      errors++; $display("FAIL drain_head: got valid=%b pc=%h expected 1/00000404",
                         bus.out_valid, bus.out_pc);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || obs !== 102'h0) begin
      errors++; $display("FAIL async_reset: got valid=%b in_ready=%b fields=%h expected 0/0/0",
                         bus.out_valid, bus.in_ready, obs);
    end
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: got valid=%b in_ready=%b expected 0/1",
                         bus.out_valid, bus.in_ready);
    end
    push_one(32'hEF123456, 32'h410);
    @(negedge clk);
    checks++;
    if (bus.out_pc !== 32'h410 || bus.out_class !== 3'd4) begin
      errors++; $display("FAIL reset_recover: got pc=%h class=%0d expected 00000410/4",
                         bus.out_pc, bus.out_class);
    end
  endtask

  initial begin
    test_reset();
    test_decode_classes();
    test_back_to_back();
    test_flush();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
